// File: rtl/leaf_pkg.sv
// Shared leaf definitions: default payload/address widths and the word+valid handshake bundle
// used by the leaf shells and the user-side FIFOs.
package leaf_pkg;

    localparam int LEAF_PAYLOAD_BITS = 32;
    localparam int LEAF_ADDR_BITS    = 6;

    typedef struct packed {
        logic [31:0] data;
        logic        vld;
    } leaf_hs_t;

endpackage

// File: rtl/leaf_user_in_fifo_if.sv
// Handshake bundle between the leaf interface, the user-side input FIFO and the user kernel.
// A word moves on any rising edge where its vld and ack are both high; vld never waits on ack,
// and data is held stable while vld is high and ack is low.
interface leaf_user_in_fifo_if
    import leaf_pkg::*;
#(
    parameter int PAYLOAD_BITS = LEAF_PAYLOAD_BITS
);

    logic [PAYLOAD_BITS-1:0] dout_leaf_interface2user;
    logic                    vld_interface2user;
    logic                    ack_user2interface;
    logic [PAYLOAD_BITS-1:0] dout_fifo2user;
    logic                    vld_fifo2user;
    logic                    ack_user2fifo;

    modport slave (
        input  dout_leaf_interface2user,
        input  vld_interface2user,
        output ack_user2interface,
        output dout_fifo2user,
        output vld_fifo2user,
        input  ack_user2fifo
    );

    modport master (
        output dout_leaf_interface2user,
        output vld_interface2user,
        input  ack_user2interface,
        input  dout_fifo2user,
        input  vld_fifo2user,
        output ack_user2fifo
    );

endinterface

// File: rtl/leaf_fifo_ram.sv
// Simple dual-port storage for the leaf FIFOs: one write port, one read port with a
// registered read that holds its value when not enabled. No reset on the array or read register.
module leaf_fifo_ram #(
    parameter int DATA_BITS = 32,
    parameter int ADDR_BITS = 6
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [DATA_BITS-1:0] wr_data,
    input  logic                 rd_en,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output logic [DATA_BITS-1:0] rd_data
);

    logic [DATA_BITS-1:0] mem [0:(1<<ADDR_BITS)-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/leaf_user_in_fifo.sv
// Elastic first-word-fall-through buffer between a leaf input port and the user kernel.
// Defining LEAF_FIFO_STATS_EN adds the hwm and stall_cycles statistics outputs.
module leaf_user_in_fifo
    import leaf_pkg::*;
#(
    parameter int PAYLOAD_BITS = LEAF_PAYLOAD_BITS,
    parameter int ADDR_BITS    = LEAF_ADDR_BITS,
    parameter int AFULL_MARGIN = 4
) (
    input  logic                 clk_user,
    input  logic                 reset,
    leaf_user_in_fifo_if.slave   bus,
    output logic [ADDR_BITS:0]   count,
    output logic                 almost_full
`ifdef LEAF_FIFO_STATS_EN
    ,
    output logic [ADDR_BITS:0]   hwm,
    output logic [31:0]          stall_cycles
`endif
);

    localparam int DEPTH = 1 << ADDR_BITS;
    localparam logic [ADDR_BITS:0] DEPTH_C = (ADDR_BITS+1)'(DEPTH);
    localparam logic [ADDR_BITS:0] AFULL_C = (ADDR_BITS+1)'(DEPTH - AFULL_MARGIN);

    logic [ADDR_BITS-1:0]    wr_ptr;
    logic [ADDR_BITS-1:0]    rd_ptr;
    logic                    out_vld;
    logic                    out_loaded;
    logic                    push;
    logic                    pop;
    logic                    load;
    logic [ADDR_BITS:0]      ram_count;
    logic [ADDR_BITS:0]      count_next;
    logic [PAYLOAD_BITS-1:0] ram_q;

    // Full/empty come from the word count; a pop never frees room for a push in the same cycle.
    assign bus.ack_user2interface = (count < DEPTH_C);
    assign almost_full            = (count >= AFULL_C);

    assign push       = bus.vld_interface2user && bus.ack_user2interface;
    assign pop        = out_vld && bus.ack_user2fifo;
    assign ram_count  = count - {{ADDR_BITS{1'b0}}, out_vld};
    assign load       = (ram_count != '0) && (!out_vld || pop);
    assign count_next = count + (ADDR_BITS+1)'(push) - (ADDR_BITS+1)'(pop);

    leaf_fifo_ram #(
        .DATA_BITS (PAYLOAD_BITS),
        .ADDR_BITS (ADDR_BITS)
    ) u_ram (
        .clk     (clk_user),
        .wr_en   (push),
        .wr_addr (wr_ptr),
        .wr_data (bus.dout_leaf_interface2user),
        .rd_en   (load),
        .rd_addr (rd_ptr),
        .rd_data (ram_q)
    );

    // The RAM read register is the output register; until its first load after reset it reads as zero.
    assign bus.dout_fifo2user = out_loaded ? ram_q : '0;
    assign bus.vld_fifo2user  = out_vld;

    always_ff @(posedge clk_user) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            out_vld    <= 1'b0;
            out_loaded <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ADDR_BITS'(1);
            end
            if (load) begin
                rd_ptr     <= rd_ptr + ADDR_BITS'(1);
                out_vld    <= 1'b1;
                out_loaded <= 1'b1;
            end else if (pop) begin
                out_vld <= 1'b0;
            end
            count <= count_next;
        end
    end

`ifdef LEAF_FIFO_STATS_EN
    always_ff @(posedge clk_user) begin
        if (reset) begin
            hwm          <= '0;
            stall_cycles <= '0;
        end else begin
            if (count_next > hwm) begin
                hwm <= count_next;
            end
            if (bus.vld_interface2user && !bus.ack_user2interface &&
                (stall_cycles != 32'hFFFF_FFFF)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_leaf_user_in_fifo.sv
// Bench for leaf_user_in_fifo: queue-based reference model with per-word arrival stamps,
// directed boundary scenarios and a randomized push/pop run.
module tb_leaf_user_in_fifo;

    localparam int W      = 32;
    localparam int AB     = 3;
    localparam int DEPTH  = 8;
    localparam int MARGIN = 4;

    logic          clk_user = 1'b0;
    logic          reset;
    logic [AB:0]   count;
    logic          almost_full;
`ifdef LEAF_FIFO_STATS_EN
    logic [AB:0]   hwm;
    logic [31:0]   stall_cycles;
`endif

    leaf_user_in_fifo_if #(.PAYLOAD_BITS(W)) bus ();

    leaf_user_in_fifo #(
        .PAYLOAD_BITS (W),
        .ADDR_BITS    (AB),
        .AFULL_MARGIN (MARGIN)
    ) dut (
        .clk_user     (clk_user),
        .reset        (reset),
        .bus          (bus),
        .count        (count),
        .almost_full  (almost_full)
`ifdef LEAF_FIFO_STATS_EN
        ,
        .hwm          (hwm),
        .stall_cycles (stall_cycles)
`endif
    );

    // clock
    always #5 clk_user = ~clk_user;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a word becomes visible to the kernel one edge after the edge that stored it.
    logic [W-1:0] exp_q[$];
    int unsigned  stamp_q[$];
    int unsigned  edge_n     = 0;
    bit           model_live = 0;
    int unsigned  exp_hwm    = 0;
    int unsigned  exp_stall  = 0;

    always @(posedge clk_user) begin : model_b
        bit pop_ok;
        bit push_ok;
        bit stall_hit;
        pop_ok    = (exp_q.size() > 0) && (stamp_q[0] < edge_n) && (bus.ack_user2fifo === 1'b1);
        push_ok   = (bus.vld_interface2user === 1'b1) && (exp_q.size() < DEPTH);
        stall_hit = (bus.vld_interface2user === 1'b1) && (exp_q.size() >= DEPTH);
        edge_n++;
        if (reset === 1'b1) begin
            exp_q.delete();
            stamp_q.delete();
            exp_hwm    = 0;
            exp_stall  = 0;
            model_live = 1;
        end else if (model_live) begin
            if (stall_hit && exp_stall != 32'hFFFF_FFFF) exp_stall++;
            if (pop_ok) begin
                void'(exp_q.pop_front());
                void'(stamp_q.pop_front());
            end
            if (push_ok) begin
                exp_q.push_back(bus.dout_leaf_interface2user);
                stamp_q.push_back(edge_n);
            end
            if (exp_q.size() > exp_hwm) exp_hwm = exp_q.size();
        end
    end

    // Monitor / scoreboard
    int  max_count = 0;
    bit  tp_arm    = 0;
    int  tp_n      = 0;
    int  tp_first  = 0;
    int  tp_last   = 0;

    initial begin
        forever begin
            bit exp_vld;
            @(negedge clk_user);
            #1;
            if (model_live) begin
                exp_vld = (exp_q.size() > 0) && (stamp_q[0] < edge_n);
                check("vld_fifo2user", bus.vld_fifo2user, exp_vld);
                check("count", count, exp_q.size());
                check("ack_user2interface", bus.ack_user2interface, exp_q.size() < DEPTH);
                check("almost_full", almost_full, exp_q.size() >= DEPTH - MARGIN);
                if (exp_vld && bus.vld_fifo2user === 1'b1)
                    check("dout_fifo2user", bus.dout_fifo2user, exp_q[0]);
`ifdef LEAF_FIFO_STATS_EN
                check("hwm", hwm, exp_hwm);
                check("stall_cycles", stall_cycles, exp_stall);
`endif
                if (int'(count) > max_count) max_count = int'(count);
                if (tp_arm && bus.vld_fifo2user === 1'b1 && bus.ack_user2fifo === 1'b1) begin
                    if (tp_n == 0) tp_first = int'(edge_n);
                    tp_last = int'(edge_n);
                    tp_n++;
                end
            end
        end
    end

    // Driver tasks
    task automatic do_reset(input int n);
        @(negedge clk_user);
        reset = 1'b1;
        bus.vld_interface2user = 1'b0;
        bus.ack_user2fifo      = 1'b0;
        repeat (n) @(negedge clk_user);
        reset = 1'b0;
    endtask

    // Returns at the negedge before the accepting edge, or drops vld after max_cycles of stall.
    task automatic push_try(input logic [W-1:0] d, input int max_cycles, output bit ok);
        ok = 0;
        @(negedge clk_user);
        bus.vld_interface2user       = 1'b1;
        bus.dout_leaf_interface2user = d;
        for (int i = 0; i < max_cycles; i++) begin
            if (bus.ack_user2interface === 1'b1) begin
                ok = 1;
                break;
            end
            if (i == max_cycles - 1) begin
                bus.vld_interface2user = 1'b0;
                break;
            end
            @(negedge clk_user);
        end
    endtask

    task automatic end_push();
        @(negedge clk_user);
        bus.vld_interface2user = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        bus.ack_user2fifo = 1'b1;
        for (int c = 0; c < budget && count != 0; c++) @(negedge clk_user);
        bus.ack_user2fifo = 1'b0;
        check(name, count, 0);
    endtask

    // Watchdog
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    bit prod_done = 0;

    initial begin
        bit           ok;
        logic [W-1:0] got[$];

        reset                        = 1'b1;
        bus.vld_interface2user       = 1'b0;
        bus.dout_leaf_interface2user = '0;
        bus.ack_user2fifo            = 1'b0;
        do_reset(2);

        check("reset_count", count, 0);
        check("reset_vld", bus.vld_fifo2user, 0);
        check("reset_dout", bus.dout_fifo2user, 0);
        check("reset_ack", bus.ack_user2interface, 1);
        check("reset_afull", almost_full, 0);

        // 1: single word, one-cycle latency
        push_try(32'hA5A5_0001, 4, ok);
        check("t1_accept", ok, 1);
        @(negedge clk_user);
        bus.vld_interface2user = 1'b0;
        check("t1_count_after_write", count, 1);
        check("t1_vld_not_yet", bus.vld_fifo2user, 0);
        check("t1_ack_stays", bus.ack_user2interface, 1);
        @(negedge clk_user);
        check("t1_vld", bus.vld_fifo2user, 1);
        check("t1_dout", bus.dout_fifo2user, 32'hA5A5_0001);
        check("t1_count", count, 1);
        bus.ack_user2fifo = 1'b1;
        @(negedge clk_user);
        bus.ack_user2fifo = 1'b0;
        check("t1_count_after_pop", count, 0);

        // 2: overfill with the kernel stalled, then drain in order
        for (int i = 0; i < 10; i++) begin
            push_try(W'(i), 2, ok);
            check("t2_accept", ok, (i < DEPTH));
        end
        check("t2_count_full", count, DEPTH);
        check("t2_ack_full", bus.ack_user2interface, 0);
        check("t2_afull", almost_full, 1);
        bus.ack_user2fifo = 1'b1;
        for (int c = 0; c < 30 && got.size() < DEPTH; c++) begin
            if (bus.vld_fifo2user === 1'b1) got.push_back(bus.dout_fifo2user);
            @(negedge clk_user);
        end
        bus.ack_user2fifo = 1'b0;
        check("t2_drain_n", got.size(), DEPTH);
        foreach (got[k]) check("t2_order", got[k], k);

        // 3: push refused on a full FIFO even when a pop happens in the same cycle
        for (int i = 0; i < DEPTH; i++) push_try(32'h100 + W'(i), 4, ok);
        @(negedge clk_user);
        bus.vld_interface2user       = 1'b1;
        bus.dout_leaf_interface2user = 32'h200;
        bus.ack_user2fifo            = 1'b1;
        check("t3_ack_full", bus.ack_user2interface, 0);
        @(negedge clk_user);
        bus.ack_user2fifo = 1'b0;
        check("t3_count_pop_only", count, DEPTH - 1);
        @(negedge clk_user);
        bus.vld_interface2user = 1'b0;
        check("t3_count_push_next", count, DEPTH);
        drain("t3_drain", 40);

        // 4: random run, kernel ack at 50%
        fork
            begin
                int sent = 0;
                while (sent < 1000) begin
                    push_try($urandom, 60, ok);
                    check("t4_push", ok, 1);
                    sent++;
                end
                end_push();
                prod_done = 1;
            end
            begin
                for (int c = 0; c < 20000 && !(prod_done && count == 0); c++) begin
                    @(negedge clk_user);
                    bus.ack_user2fifo = 1'($urandom_range(0, 1));
                end
                bus.ack_user2fifo = 1'b0;
            end
        join
        check("t4_drained", count, 0);
        check("t4_max_count", max_count <= DEPTH, 1);

        // 4b: sustained throughput with the kernel always ready
        tp_arm = 1;
        bus.ack_user2fifo = 1'b1;
        for (int i = 0; i < 64; i++) begin
            push_try(32'hC000_0000 + W'(i), 4, ok);
            check("t4_tp_push", ok, 1);
        end
        end_push();
        drain("t4_tp_drain", 40);
        tp_arm = 0;
        check("t4_tp_words", tp_n, 64);
        check("t4_tp_span", tp_last - tp_first, 63);

        // 5: reset with words held
        for (int i = 0; i < 5; i++) push_try(32'hDEAD_0000 + W'(i), 4, ok);
        end_push();
        check("t5_count_before", count, 5);
        do_reset(1);
        check("t5_count", count, 0);
        check("t5_vld", bus.vld_fifo2user, 0);
        check("t5_dout", bus.dout_fifo2user, 0);
        bus.ack_user2fifo = 1'b1;
        repeat (5) begin
            @(negedge clk_user);
            check("t5_no_stale", bus.vld_fifo2user, 0);
        end
        for (int i = 0; i < 3; i++) push_try(32'h5EED_0000 + W'(i), 4, ok);
        end_push();
        drain("t5_drain", 20);

`ifdef LEAF_FIFO_STATS_EN
        // 6: statistics
        do_reset(1);
        for (int i = 0; i < 6; i++) push_try(32'h600 + W'(i), 4, ok);
        end_push();
        drain("t6_drain_a", 20);
        check("t6_hwm6", hwm, 6);
        check("t6_stall0", stall_cycles, 0);
        for (int i = 0; i < DEPTH; i++) push_try(32'h700 + W'(i), 4, ok);
        @(negedge clk_user);
        bus.dout_leaf_interface2user = 32'h7FF;
        repeat (3) @(negedge clk_user);
        bus.vld_interface2user = 1'b0;
        check("t6_stall3", stall_cycles, 3);
        check("t6_hwm8", hwm, DEPTH);
        drain("t6_drain_b", 20);
`endif

        repeat (3) @(negedge clk_user);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
